// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises, debounces and edge-detects raw push-button pins for the
//   turn-signal control logic. Each channel is normalised to pressed = 1,
//   passed through a 2-flop synchroniser, then qualified by a 4-state FSM
//   that only accepts a new value after it has been stable for
//   DEBOUNCE_CYCLES consecutive cycles.
//
// Optional feature macro: BUTTON_TOGGLE_EN
//   defined   -> per-channel toggle register, flips on each accepted press
//   undefined -> no toggle registers, btn_toggle tied to 0
//
// Ports
//   clk          50 MHz board clock
//   clear        asynchronous active-low reset
//   buttons_raw  raw asynchronous pins (polarity set by ACTIVE_LOW)
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle pulse on accepted press
//   btn_release  one-cycle pulse on accepted release
//   btn_toggle   flips on each accepted press (BUTTON_TOGGLE_EN only)

module button_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_p,
  output logic toggle
);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pressed_in;
  logic             s1, s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign pressed_in = (ACTIVE_LOW != 0) ? ~raw : raw;

  // Synchroniser resets to the released value so a button held through
  // reset is seen as a fresh press once reset lifts.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pressed_in;
      s2 <= s1;
    end
  end

`ifdef BUTTON_TOGGLE_EN
  logic tog_q;
  assign toggle = tog_q;
`else
  assign toggle = 1'b0;
`endif

  // Counter only advances inside a WAIT state and the state is left when it
  // reaches CNT_LAST, so it can never wrap. Any disagreeing sample sends the
  // FSM back to its stable state with the count cleared.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= RELEASED;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
`ifdef BUTTON_TOGGLE_EN
      tog_q     <= 1'b0;
`endif
    end else begin
      press     <= 1'b0;
      release_p <= 1'b0;
      case (state)
        RELEASED: begin
          level <= 1'b0;
          if (s2) begin
            cnt   <= '0;
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!s2) begin
            cnt   <= '0;
            state <= RELEASED;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= PRESSED;
            level <= 1'b1;
            press <= 1'b1;
`ifdef BUTTON_TOGGLE_EN
            tog_q <= ~tog_q;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          level <= 1'b1;
          if (!s2) begin
            cnt   <= '0;
            state <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (s2) begin
            cnt   <= '0;
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= RELEASED;
            level     <= 1'b0;
            release_p <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= RELEASED;
        end
      endcase
    end
  end

endmodule

module button_conditioner #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_toggle
);

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_lane
    button_conditioner_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk       (clk),
      .clear     (clear),
      .raw       (buttons_raw[g]),
      .level     (btn_level[g]),
      .press     (btn_press[g]),
      .release_p (btn_release[g]),
      .toggle    (btn_toggle[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int N = 4;
  localparam int D = 4;
  localparam int HMAX = 8192;

  logic         clk = 1'b0;
  logic         clear;
  logic [N-1:0] buttons_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_toggle;

  button_conditioner #(
    .N_BUTTONS       (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .buttons_raw (buttons_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_toggle  (btn_toggle)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: keeps the pressed-normalised value seen at every edge
  // (0 while in reset). A channel's level flips when the D+1 samples that
  // have made it through the two-stage synchroniser all disagree with it.
  logic [N-1:0] hist [HMAX];
  int           cyc;
  logic [N-1:0] m_level, m_press, m_rel, m_tog;

  task automatic model_reset();
    m_level = '0; m_press = '0; m_rel = '0; m_tog = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic c);
    cyc++;
    hist[cyc] = c ? ~r : '0;
    if (!c) begin
      model_reset();
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int ch = 0; ch < N; ch++) begin
        bit stable = 1'b1;
        for (int j = 0; j <= D; j++)
          if (hist[cyc-2-j][ch] == m_level[ch]) stable = 1'b0;
        if (stable) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) begin
            m_press[ch] = 1'b1;
`ifdef BUTTON_TOGGLE_EN
            m_tog[ch] = ~m_tog[ch];
`endif
          end else begin
            m_rel[ch] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
  endtask

  task automatic compare_all();
    chk("level",   btn_level,   m_level);
    chk("press",   btn_press,   m_press);
    chk("release", btn_release, m_rel);
    chk("toggle",  btn_toggle,  m_tog);
  endtask

  task automatic step(input logic [N-1:0] r, input logic c);
    buttons_raw = r;
    clear = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b1);
  endtask

  typedef struct {
    logic         clr;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [N-1:0] r;
    int presses;
    int hl;
    logic tog_exp;

    for (int i = 0; i < HMAX; i++) hist[i] = '0;
    cyc = D + 2;
    model_reset();
    clear = 1'b1;
    buttons_raw = '1;
    #3 clear = 1'b0;

    // Reset with all buttons held, then release reset.
    for (int i = 0; i < 10; i++) begin
      tbl[i].clr = (i >= 2);
      tbl[i].raw = 4'b0000;
      tbl[i].lvl = (i >= 8) ? 4'b1111 : 4'b0000;
      tbl[i].prs = (i == 8) ? 4'b1111 : 4'b0000;
      tbl[i].rls = 4'b0000;
    end
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].raw, tbl[i].clr);
      chk($sformatf("tbl%0d_level", i),   btn_level,   tbl[i].lvl);
      chk($sformatf("tbl%0d_press", i),   btn_press,   tbl[i].prs);
      chk($sformatf("tbl%0d_release", i), btn_release, tbl[i].rls);
    end
    hold(4'b1111, 8);

    // Clean press / release on bit 2.
    for (int i = 1; i <= 20; i++) begin
      step(4'b1011, 1'b1);
      chk("b2_press", btn_press, (i == 7) ? 4'b0100 : 4'b0000);
    end
    chk("b2_level_held", btn_level, 4'b0100);
    for (int i = 1; i <= 10; i++) begin
      step(4'b1111, 1'b1);
      chk("b2_release", btn_release, (i == 7) ? 4'b0100 : 4'b0000);
    end

    // Bounce on bit 0 with 3-cycle runs, final fall at i=27.
    presses = 0;
    for (int i = 0; i <= 40; i++) begin
      r = 4'b1111;
      r[0] = (i < 27) ? ((i / 3) % 2 == 0) : 1'b0;
      step(r, 1'b1);
      chk("bounce_press", btn_press, (i == 33) ? 4'b0001 : 4'b0000);
      if (btn_press[0]) presses++;
    end
    n_total++;
    if (presses == 1) n_pass++;
    else $display("FAIL bounce_count got=%0d expected=1", presses);
    hold(4'b1111, 8);

    // Simultaneous press on bits 1 and 3.
    for (int i = 1; i <= 10; i++) begin
      step(4'b0101, 1'b1);
      chk("simul_press", btn_press, (i == 7) ? 4'b1010 : 4'b0000);
    end
    hold(4'b1111, 8);

    // Mid-qualification reset while bit 3 is already accepted.
    hold(4'b0111, 8);
    hold(4'b0110, 5);
    #2 clear = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("mq_level_now", btn_level, 4'b0000);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0110, 1'b1);
      chk("mq_repress", btn_press, (i == 7) ? 4'b1001 : 4'b0000);
    end
    hold(4'b1111, 8);

    // Toggle: three accepted presses on bit 1 from a fresh reset.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      for (int i = 1; i <= 8; i++) begin
        step(4'b1101, 1'b1);
`ifdef BUTTON_TOGGLE_EN
        tog_exp = (i >= 7) ? (n % 2 == 1) : (n % 2 == 0);
`else
        tog_exp = 1'b0;
`endif
        if (i == 6 || i == 7) begin
          n_total++;
          if (btn_toggle[1] === tog_exp) n_pass++;
          else $display("FAIL toggle_b1 n=%0d i=%0d got=%b expected=%b", n, i, btn_toggle[1], tog_exp);
        end
      end
      hold(4'b1111, 8);
    end

    // Randomised stimulus against the model.
    r = 4'b1111;
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 49) == 0) begin
        step(r, 1'b0);
        step(r, 1'b0);
      end else begin
        r = r ^ N'($urandom & $urandom);
        hl = $urandom_range(1, 7);
        for (int k = 0; k < hl; k++) step(r, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
